// File: rtl/mic_array_pkg.sv
// Shared types and defaults for the microphone-array I2S capture path.
package mic_array_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } mic_state_e;

    localparam logic [1:0] CH_SD0_L = 2'd0;
    localparam logic [1:0] CH_SD0_R = 2'd1;
    localparam logic [1:0] CH_SD1_L = 2'd2;
    localparam logic [1:0] CH_SD1_R = 2'd3;

    localparam int DEF_CLK_DIV        = 16;
    localparam int DEF_SAMPLE_BITS    = 24;
    localparam int DEF_SLOT_BITS      = 32;
    localparam int DEF_DISCARD_FRAMES = 2;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: SCK divider, word select, SCK-rise strobe and
// the frame bit counter that advances on every SCK fall.
module i2s_clkgen #(
    parameter int CLK_DIV   = 16,
    parameter int SLOT_BITS = 32,
    localparam int BW       = $clog2(2 * SLOT_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          sck,
    output logic          ws,
    output logic          sck_rise,
    output logic [BW-1:0] bit_cnt
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] LAST = BW'(2 * SLOT_BITS - 1);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sck_q, sck_d;
    logic          term, sck_fall;

    assign term     = (div_q == DW'(CLK_DIV - 1));
    assign sck_rise = run && term && !sck_q;
    assign sck_fall = run && term && sck_q;

    always_comb begin
        div_d = '0;
        sck_d = 1'b0;
        bit_d = '0;
        if (run) begin
            div_d = term ? '0 : div_q + 1'b1;
            sck_d = term ? ~sck_q : sck_q;
            bit_d = bit_q;
            if (sck_fall) begin
                bit_d = (bit_q == LAST) ? '0 : bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
        end
    end

    assign sck     = sck_q;
    assign ws      = bit_q[BW-1];
    assign bit_cnt = bit_q;

endmodule

// File: rtl/i2s_mic_capture.sv
// I2S master receiver for the 4-mic array: two stereo lines into a frame bank.
// Define I2S_MIC_TESTPAT_EN to feed the deserializers from an internal pattern.
module i2s_mic_capture
    import mic_array_pkg::*;
#(
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int SAMPLE_BITS    = DEF_SAMPLE_BITS,
    parameter int SLOT_BITS      = DEF_SLOT_BITS,
    parameter int DISCARD_FRAMES = DEF_DISCARD_FRAMES
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic [1:0]  sd,
    output logic        i2s_sck,
    output logic        i2s_ws,
    input  logic [1:0]  select,
    output logic [31:0] mic_data,
    output logic        read_ready,
    output logic [15:0] frame_count
);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int PW = BW - 1;
    localparam int SB = SAMPLE_BITS;

    mic_state_e    state_q, state_d;
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    rdly_q, rdly_d;
    logic [SB-1:0] sh_q [2];
    logic [SB-1:0] sh_d [2];
    logic [SB-1:0] word_q [4];
    logic [SB-1:0] word_d [4];
    logic [SB-1:0] bank_q [4];
    logic [SB-1:0] bank_d [4];
    logic [7:0]    warm_q, warm_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          ready_q, ready_d;

    logic          run, sck_rise, cap, frame_done, in_data;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pos;
    logic [1:0]    cap_bits;
    logic [SB-1:0] sel_w;

    assign run = enable && (state_q != OFF);

    i2s_clkgen #(
        .CLK_DIV  (CLK_DIV),
        .SLOT_BITS(SLOT_BITS)
    ) u_clkgen (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .run     (run),
        .sck     (i2s_sck),
        .ws      (i2s_ws),
        .sck_rise(sck_rise),
        .bit_cnt (bit_cnt)
    );

    // bit_cnt only moves on SCK fall, so it still names the sampled bit here
    assign cap        = run && rdly_q[1];
    assign pos        = bit_cnt[PW-1:0];
    assign in_data    = (pos != '0) && (pos <= PW'(SB));
    assign frame_done = cap && (bit_cnt == BW'(2 * SLOT_BITS - 1));

`ifdef I2S_MIC_TESTPAT_EN
    logic [21:0] pat_q, pat_d;
    logic [23:0] pat_w [2];
    logic [PW-1:0] pidx;

    always_comb begin
        pidx = PW'(SB) - pos;
        for (int l = 0; l < 2; l++) begin
            pat_w[l]    = {l[0], bit_cnt[BW-1], pat_q};
            cap_bits[l] = pat_w[l][pidx];
        end
        pat_d = pat_q;
        if (state_q == OFF && enable) begin
            pat_d = '0;
        end else if (run && frame_done) begin
            pat_d = pat_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pat_q <= '0;
        else          pat_q <= pat_d;
    end
`else
    assign cap_bits = sync2_q;
`endif

    always_comb begin
        sync1_d     = sd;
        sync2_d     = sync1_q;
        rdly_d      = run ? {rdly_q[0], sck_rise} : 2'b00;
        state_d     = state_q;
        warm_d      = warm_q;
        frame_cnt_d = frame_cnt_q;
        ready_d     = 1'b0;
        sh_d        = sh_q;
        word_d      = word_q;
        bank_d      = bank_q;
        if (cap && in_data) begin
            for (int l = 0; l < 2; l++) begin
                sh_d[l] = {sh_q[l][SB-2:0], cap_bits[l]};
                if (pos == PW'(SB)) begin
                    word_d[{l[0], bit_cnt[BW-1]}] = sh_d[l];
                end
            end
        end
        unique case (state_q)
            OFF: begin
                if (enable) begin
                    state_d     = WARMUP;
                    warm_d      = '0;
                    frame_cnt_d = '0;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_d = OFF;
                end else if (frame_done) begin
                    warm_d = warm_q + 1'b1;
                    if (warm_d == 8'(DISCARD_FRAMES)) state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = OFF;
                end else if (frame_done) begin
                    bank_d      = word_q;
                    ready_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= OFF;
            sync1_q     <= '0;
            sync2_q     <= '0;
            rdly_q      <= '0;
            sh_q        <= '{default: '0};
            word_q      <= '{default: '0};
            bank_q      <= '{default: '0};
            warm_q      <= '0;
            frame_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rdly_q      <= rdly_d;
            sh_q        <= sh_d;
            word_q      <= word_d;
            bank_q      <= bank_d;
            warm_q      <= warm_d;
            frame_cnt_q <= frame_cnt_d;
            ready_q     <= ready_d;
        end
    end

    assign sel_w       = bank_q[select];
    assign mic_data    = {{(32 - SB){sel_w[SB-1]}}, sel_w};
    assign read_ready  = ready_q;
    assign frame_count = frame_cnt_q;

endmodule
